// File: rtl/log_arb_pkg.sv
// Shared constants and FSM state type for the two-source log-line arbiter.
package log_arb_pkg;

  localparam int MAX_LINE_DEFAULT = 64;

  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_IDLE  = 8'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/log_rr_pick.sv
// Two-way round-robin pick: the source named by rr wins if valid, otherwise the other one.
module log_rr_pick (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (!rr) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      if (valid[1])      grant = 2'b10;
      else if (valid[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/log_line_arbiter.sv
// Locks the trace-checker character stream to one source from '^' to '#', aborting on stall or overlong lines.
// Defining LOG_ARB_RESULT_EN adds capture of the per-line checker verdict on res_*.
module log_line_arbiter
  import log_arb_pkg::*;
#(
  parameter int MAX_LINE = MAX_LINE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s0_valid,
  input  logic [7:0] s0_char,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_char,
  output logic       s1_ready,
  output logic [7:0] chk_char,
  input  logic [1:0] chk_format_type,
  input  logic [3:0] chk_error_code,
  output logic       abort,
  output logic       res_valid,
  output logic       res_src,
  output logic [1:0] res_format,
  output logic [3:0] res_error,
  output arb_state_e dbg_state,
  output logic       dbg_owner,
  output logic       dbg_rr
);

  localparam int CNT_W = $clog2(MAX_LINE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LINE);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_e       state_q;
  logic             rr_q;
  logic             owner_q;
  logic             abort_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       chk_char_q;

  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             own_valid;
  logic             at_max;
  logic             acc;
  logic             acc_src;
  logic [7:0]       acc_char;
  logic [CNT_W-1:0] cnt_inc;

  log_rr_pick u_rr_pick (
    .valid ({s1_valid, s0_valid}),
    .rr    (rr_q),
    .grant (grant)
  );

  assign own_valid = owner_q ? s1_valid : s0_valid;
  assign at_max    = (cnt_q >= MAX_CNT);
  assign cnt_inc   = at_max ? cnt_q : cnt_q + ONE_CNT;

  // Handshake: a character transfers on the rising edge where sN_valid and sN_ready are both
  // high; ready is combinational from the current valids and is held low during reset.
  always_comb begin
    ready = 2'b00;
    if (!reset) begin
      if (state_q == ST_IDLE) ready = grant;
      else if (!at_max)       ready = owner_q ? {own_valid, 1'b0} : {1'b0, own_valid};
    end
  end

  assign acc      = |ready;
  assign acc_src  = ready[1];
  assign acc_char = ready[1] ? s1_char : s0_char;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      chk_char_q <= CH_IDLE;
      abort_q    <= 1'b0;
    end else begin
      chk_char_q <= CH_IDLE;
      abort_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Anything other than a line start is dropped without moving the pointer.
          if (acc && acc_char == CH_CARET) begin
            chk_char_q <= acc_char;
            owner_q    <= acc_src;
            cnt_q      <= ONE_CNT;
            state_q    <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (acc) begin
            chk_char_q <= acc_char;
            if (acc_char == CH_HASH) begin
              state_q <= ST_IDLE;
              rr_q    <= ~owner_q;
            end else if (acc_char == CH_CARET) begin
              cnt_q <= ONE_CNT;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            // Owner stalled or the line hit MAX_LINE: give the other source the next turn.
            abort_q <= 1'b1;
            state_q <= ST_IDLE;
            rr_q    <= ~owner_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s0_ready  = ready[0];
  assign s1_ready  = ready[1];
  assign chk_char  = chk_char_q;
  assign abort     = abort_q;
  assign dbg_state = state_q;
  assign dbg_owner = owner_q;
  assign dbg_rr    = rr_q;

`ifdef LOG_ARB_RESULT_EN
  logic       hash_acc;
  logic [1:0] hash_pipe_q;
  logic [1:0] src_pipe_q;
  logic       res_valid_q;
  logic       res_src_q;
  logic [1:0] res_format_q;
  logic [3:0] res_error_q;

  assign hash_acc = (state_q == ST_LOCK) && acc && (acc_char == CH_HASH);

  // The verdict for a '#' accepted at edge k is on the checker inputs just before edge k+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      hash_pipe_q  <= 2'b00;
      src_pipe_q   <= 2'b00;
      res_valid_q  <= 1'b0;
      res_src_q    <= 1'b0;
      res_format_q <= 2'b00;
      res_error_q  <= 4'b0000;
    end else begin
      hash_pipe_q  <= {hash_pipe_q[0], hash_acc};
      src_pipe_q   <= {src_pipe_q[0], owner_q};
      res_valid_q  <= hash_pipe_q[1];
      res_src_q    <= hash_pipe_q[1] & src_pipe_q[1];
      res_format_q <= hash_pipe_q[1] ? chk_format_type : 2'b00;
      res_error_q  <= hash_pipe_q[1] ? chk_error_code : 4'b0000;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_src    = res_src_q;
  assign res_format = res_format_q;
  assign res_error  = res_error_q;
`else
  logic unused_chk;
  assign unused_chk = ^{chk_format_type, chk_error_code};

  assign res_valid  = 1'b0;
  assign res_src    = 1'b0;
  assign res_format = 2'b00;
  assign res_error  = 4'b0000;
`endif

endmodule

// File: tb/tb_log_line_arbiter.sv
// Bench for log_line_arbiter: IDLE arbitration table, directed line sequences and a random run
// against a line-level reference model. Honours LOG_ARB_RESULT_EN when it is defined.
module tb_log_line_arbiter;
  import log_arb_pkg::*;

  localparam int ML = 64;

  typedef struct {
    logic       rr1;
    logic       v0;
    logic [7:0] c0;
    logic       v1;
    logic [7:0] c1;
    logic [1:0] rdy;
    logic [7:0] chk;
  } vec_t;

  typedef struct {
    int         due;
    logic       src;
    logic [1:0] fmt;
    logic [3:0] err;
  } res_t;

  logic       clk;
  logic       reset;
  logic       s0_valid, s1_valid;
  logic [7:0] s0_char, s1_char;
  logic       s0_ready, s1_ready;
  logic [7:0] chk_char;
  logic [1:0] chk_format_type;
  logic [3:0] chk_error_code;
  logic       abort, res_valid, res_src;
  logic [1:0] res_format;
  logic [3:0] res_error;
  arb_state_e dbg_state;
  logic       dbg_owner, dbg_rr;

  log_line_arbiter #(.MAX_LINE(ML)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_char(s0_char), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_char(s1_char), .s1_ready(s1_ready),
    .chk_char(chk_char), .chk_format_type(chk_format_type), .chk_error_code(chk_error_code),
    .abort(abort), .res_valid(res_valid), .res_src(res_src),
    .res_format(res_format), .res_error(res_error),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_rr(dbg_rr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trace-checker stand-in: returns a verdict in the cycle after it has consumed a '#'.
  logic [1:0] fmt_val;
  logic [3:0] err_val;
  logic [7:0] stub_last;
  initial begin
    chk_format_type = 2'b00;
    chk_error_code  = 4'b0000;
    stub_last       = 8'h00;
  end
  always @(negedge clk) begin
    chk_format_type = (stub_last == CH_HASH) ? fmt_val : 2'b00;
    chk_error_code  = (stub_last == CH_HASH) ? err_val : 4'b0000;
    stub_last       = chk_char;
  end

  // scoreboard / reference model state
  int         checks = 0;
  int         failures = 0;
  int         edge_cnt = 0;
  int         m_owner, m_len, m_rr;
  logic [1:0] m_rdy;
  logic [7:0] m_chk;
  logic       m_abort;
  res_t       rq[$];
  logic [7:0] exp_q[$];
  logic [1:0] last_rdy;
  int         abort_cnt = 0, fwd_cnt = 0, res_cnt = 0;
  int         abort_edge = -1, res_edge = -1;
  logic [6:0] res_snap;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // One clock of the line rules: who gets ready, what reaches the checker, what ends a line.
  task automatic model_step(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1);
    logic [7:0] c[2];
    int g;
    c[0] = c0;
    c[1] = c1;
    m_rdy = 2'b00;
    m_chk = CH_IDLE;
    m_abort = 1'b0;
    if (m_owner < 0) begin
      g = v[m_rr] ? m_rr : (v[1-m_rr] ? 1 - m_rr : -1);
      if (g >= 0) begin
        m_rdy[g] = 1'b1;
        if (c[g] == CH_CARET) begin
          m_chk = CH_CARET;
          m_owner = g;
          m_len = 1;
        end
      end
    end else if (m_len >= ML || !v[m_owner]) begin
      m_abort = 1'b1;
      m_rr = 1 - m_owner;
      m_owner = -1;
    end else begin
      m_rdy[m_owner] = 1'b1;
      m_chk = c[m_owner];
      if (c[m_owner] == CH_HASH) begin
`ifdef LOG_ARB_RESULT_EN
        rq.push_back('{edge_cnt + 3, m_owner[0], fmt_val, err_val});
`endif
        m_rr = 1 - m_owner;
        m_owner = -1;
      end else if (c[m_owner] == CH_CARET) begin
        m_len = 1;
      end else begin
        m_len++;
      end
    end
  endtask

  task automatic check_outputs();
    logic rv, rs;
    logic [1:0] rf;
    logic [3:0] re;
    rv = 1'b0; rs = 1'b0; rf = 2'b00; re = 4'b0000;
    if (rq.size() > 0 && rq[0].due == edge_cnt) begin
      rv = 1'b1; rs = rq[0].src; rf = rq[0].fmt; re = rq[0].err;
      rq.delete(0);
    end
    check("chk_char", chk_char, m_chk);
    check("abort", abort, m_abort);
    check("res", {res_valid, res_src, res_format, res_error}, {rv, rs, rf, re});
    check("state_lock", 32'(dbg_state), m_owner >= 0);
    if (m_owner >= 0) check("owner", dbg_owner, m_owner[0]);
    check("rr", dbg_rr, m_rr[0]);
    if (abort) begin abort_cnt++; abort_edge = edge_cnt; end
    if (chk_char != CH_IDLE) fwd_cnt++;
    if (res_valid) begin
      res_cnt++;
      res_edge = edge_cnt;
      res_snap = {res_src, res_format, res_error};
    end
  endtask

  // driver: apply one cycle of inputs, check ready before the edge and outputs after it
  task automatic cycle(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1);
    @(negedge clk);
    reset = 1'b0;
    s0_valid = v0; s0_char = c0; s1_valid = v1; s1_char = c1;
    #1;
    last_rdy = {s1_ready, s0_ready};
    model_step({v1, v0}, c0, c1);
    check("ready", last_rdy, m_rdy);
    @(posedge clk);
    #1;
    edge_cnt++;
    check_outputs();
  endtask

  // Reset for one edge with the inputs left as they are.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", {s1_ready, s0_ready}, 2'b00);
    @(posedge clk);
    #1;
    edge_cnt++;
    m_owner = -1; m_len = 0; m_rr = 0;
    rq.delete();
    check("rst_chk", chk_char, CH_IDLE);
    check("rst_abort", abort, 1'b0);
    check("rst_res", {res_valid, res_src, res_format, res_error}, 7'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_rr", dbg_rr, 1'b0);
  endtask

  // Two sources, each holding its next character until it is accepted.
  task automatic run_lines(input string l0, input string l1, input int budget,
                           output int hash0_edge, output int hash1_edge,
                           output int s1_first_edge, output int s1_idx63_edge);
    int i0, i1, n;
    logic a0, a1;
    i0 = 0; i1 = 0; n = 0;
    hash0_edge = -1; hash1_edge = -1; s1_first_edge = -1; s1_idx63_edge = -1;
    while ((i0 < l0.len() || i1 < l1.len()) && n < budget) begin
      a0 = (i0 < l0.len());
      a1 = (i1 < l1.len());
      cycle(a0, a0 ? l0[i0] : 8'h00, a1, a1 ? l1[i1] : 8'h00);
      if (last_rdy[0]) begin
        if (l0[i0] == CH_HASH) hash0_edge = edge_cnt;
        i0++;
      end
      if (last_rdy[1]) begin
        if (s1_first_edge < 0) s1_first_edge = edge_cnt;
        if (l1[i1] == CH_HASH) hash1_edge = edge_cnt;
        if (i1 == 63) s1_idx63_edge = edge_cnt;
        i1++;
      end
      n++;
    end
    check("run_done", (i0 >= l0.len()) && (i1 >= l1.len()), 1'b1);
  endtask

  function automatic logic [7:0] rnd_char();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2)  return CH_CARET;
    if (r == 2) return CH_HASH;
    return 8'h61 + 8'(r);
  endfunction

  vec_t vecs[9];
  string s030, s033;
  int h0, h1, f1, e63, base_fwd, base_abort, base_res;

  initial begin
    reset = 1'b1;
    s0_valid = 1'b0; s0_char = 8'h00; s1_valid = 1'b0; s1_char = 8'h00;
    fmt_val = 2'd1; err_val = 4'd3;
    m_owner = -1; m_len = 0; m_rr = 0;

    // IDLE arbitration table: {rr=1 first?, v0, c0, v1, c1, expected ready, expected chk_char}
    vecs[0] = '{1'b0, 1'b0, 8'h00,    1'b0, 8'h00,    2'b00, CH_IDLE};
    vecs[1] = '{1'b0, 1'b1, CH_CARET, 1'b0, 8'h00,    2'b01, CH_CARET};
    vecs[2] = '{1'b0, 1'b0, 8'h00,    1'b1, CH_CARET, 2'b10, CH_CARET};
    vecs[3] = '{1'b0, 1'b1, CH_CARET, 1'b1, CH_CARET, 2'b01, CH_CARET};
    vecs[4] = '{1'b0, 1'b1, 8'h61,    1'b1, CH_CARET, 2'b01, CH_IDLE};
    vecs[5] = '{1'b1, 1'b1, CH_CARET, 1'b1, CH_CARET, 2'b10, CH_CARET};
    vecs[6] = '{1'b1, 1'b1, CH_CARET, 1'b0, 8'h00,    2'b01, CH_CARET};
    vecs[7] = '{1'b1, 1'b1, CH_CARET, 1'b1, 8'h78,    2'b10, CH_IDLE};
    vecs[8] = '{1'b0, 1'b0, 8'h00,    1'b1, CH_HASH,  2'b10, CH_IDLE};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_reset();
      if (vecs[i].rr1) begin
        cycle(1'b1, CH_CARET, 1'b0, 8'h00);
        cycle(1'b1, CH_HASH, 1'b0, 8'h00);
      end
      cycle(vecs[i].v0, vecs[i].c0, vecs[i].v1, vecs[i].c1);
      check($sformatf("vec%0d_ready", i), last_rdy, vecs[i].rdy);
      check($sformatf("vec%0d_chk", i), chk_char, vecs[i].chk);
    end

    // s0 alone sends one full line; each character shows up right after its accepting edge
    do_reset();
    s030 = "^12@00003000: $1 <= 0000000a#";
    for (int i = 0; i < s030.len(); i++) exp_q.push_back(s030[i]);
    for (int i = 0; i < s030.len(); i++) begin
      cycle(1'b1, s030[i], 1'b0, 8'h00);
      check("l030_char", chk_char, exp_q.pop_front());
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00);
    check("l030_idle", chk_char, CH_IDLE);
    check("l030_rr", dbg_rr, 1'b1);

    // both sources waiting with '^': s0 first, s1 on the very next edge after s0's '#'
    do_reset();
    base_fwd = fwd_cnt; base_abort = abort_cnt;
    run_lines("^ab#", "^xy#", 40, h0, h1, f1, e63);
    check("l031_s1_follow", f1, h0 + 1);
    check("l031_fwd", fwd_cnt - base_fwd, 8);
    check("l031_no_abort", abort_cnt - base_abort, 0);

    // s0 stalls mid-line while s1 waits
    do_reset();
    base_abort = abort_cnt;
    cycle(1'b1, CH_CARET, 1'b1, CH_CARET);
    cycle(1'b1, 8'h31, 1'b1, CH_CARET);
    cycle(1'b1, 8'h32, 1'b1, CH_CARET);
    cycle(1'b1, 8'h40, 1'b1, CH_CARET);
    cycle(1'b0, 8'h00, 1'b1, CH_CARET);
    check("l032_stall_ready", last_rdy, 2'b00);
    check("l032_stall_chk", chk_char, CH_IDLE);
    check("l032_abort", abort, 1'b1);
    check("l032_idle", 32'(dbg_state), 32'(ST_IDLE));
    cycle(1'b1, 8'h33, 1'b1, CH_CARET);
    check("l032_s1_grant", last_rdy, 2'b10);
    check("l032_s1_chk", chk_char, CH_CARET);
    check("l032_abort_once", abort_cnt - base_abort, 1);
    cycle(1'b0, 8'h00, 1'b1, CH_HASH);

    // s1 sends 70 characters with no '#'
    do_reset();
    s033 = "^";
    for (int i = 1; i < 70; i++) s033 = {s033, "a"};
    base_fwd = fwd_cnt; base_abort = abort_cnt;
    run_lines("", s033, 100, h0, h1, f1, e63);
    check("l033_fwd", fwd_cnt - base_fwd, ML);
    check("l033_abort_cnt", abort_cnt - base_abort, 1);
    check("l033_abort_edge", abort_edge, e63 + 1);
    cycle(1'b0, 8'h00, 1'b1, CH_CARET);
    check("l033_restart", chk_char, CH_CARET);
    cycle(1'b0, 8'h00, 1'b1, CH_HASH);

    // verdict capture for a line owned by s1
    do_reset();
    fmt_val = 2'b10; err_val = 4'b0100;
    base_res = res_cnt;
    run_lines("", "^ab#", 20, h0, h1, f1, e63);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00);
`ifdef LOG_ARB_RESULT_EN
    check("l034_res_cnt", res_cnt - base_res, 1);
    check("l034_latency", res_edge - h1, 2);
    check("l034_fields", res_snap, {1'b1, 2'b10, 4'b0100});
`else
    check("l034_res_absent", res_cnt - base_res, 0);
`endif

    // reset in the middle of a locked line, then reset right after a '#'
    do_reset();
    base_abort = abort_cnt; base_res = res_cnt;
    cycle(1'b1, CH_CARET, 1'b0, 8'h00);
    cycle(1'b1, 8'h78, 1'b0, 8'h00);
    do_reset();
    check("l035_chk", chk_char, CH_IDLE);
    check("l035_rr", dbg_rr, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, CH_CARET);
    cycle(1'b0, 8'h00, 1'b1, CH_HASH);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00);
    check("l035_no_abort", abort_cnt - base_abort, 0);
    check("l035_no_res", res_cnt - base_res, 0);

    // random traffic against the model
    do_reset();
    fmt_val = 2'($urandom_range(1, 3));
    err_val = 4'($urandom_range(1, 15));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 8, rnd_char(), $urandom_range(0, 9) < 8, rnd_char());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
